// File: rtl/masked_state_pkg.sv
// Shared types and sizing helpers for the share-aware masked state register.
package masked_state_pkg;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_RUN  = 2'd1,
    FSM_DONE = 2'd2
  } fsm_e;

  // Round index must be able to hold ROUNDS itself (saturating value).
  function automatic int unsigned round_w(input int unsigned rounds);
    return (rounds + 1 > 1) ? int'($clog2(rounds + 1)) : 1;
  endfunction

  function automatic int unsigned lat_w(input int unsigned rf_lat);
    return (rf_lat > 1) ? int'($clog2(rf_lat)) : 1;
  endfunction

  function automatic int unsigned share_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/masked_state_reg_mux_reg.sv
// Enable + 2:1 select register; one instance holds one share, shares never mix.
module mux_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sel,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= sel ? d1 : d0;
    end
  end

endmodule

// File: rtl/masked_state_reg.sv
// Masked state register with round sequencing: loads shares, then iterates the
// round-function output ROUNDS times with RF_LAT cycles per update.
module masked_state_reg
  import masked_state_pkg::*;
#(
  parameter int unsigned SHARES = 3,
  parameter int unsigned WIDTH  = 128,
  parameter int unsigned ROUNDS = 40,
  parameter int unsigned RF_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [SHARES*WIDTH-1:0]       din,
  input  logic [SHARES*WIDTH-1:0]       rf_in,
  input  logic                          stall,
  output logic [SHARES*WIDTH-1:0]       q,
  output logic [round_w(ROUNDS)-1:0]    round,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned ROUND_W = round_w(ROUNDS);
  localparam int unsigned LAT_W   = lat_w(RF_LAT);

  localparam logic [1:0] ST_IDLE = 2'(FSM_IDLE);
  localparam logic [1:0] ST_RUN  = 2'(FSM_RUN);
  localparam logic [1:0] ST_DONE = 2'(FSM_DONE);

  localparam logic [LAT_W-1:0]   LAT_LAST   = LAT_W'(RF_LAT - 1);
  localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(ROUNDS - 1);
  localparam logic [ROUND_W-1:0] ROUND_SAT  = ROUND_W'(ROUNDS);

  logic [1:0]         state, state_nxt;
  logic [ROUND_W-1:0] round_nxt;
  logic [LAT_W-1:0]   lat_cnt, lat_nxt;
  logic               load_c, update_c;

  // Next-state, counter and share-bank control decode
  always_comb begin
    state_nxt = state;
    round_nxt = round;
    lat_nxt   = lat_cnt;
    load_c    = 1'b0;
    update_c  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load_c    = 1'b1;
          round_nxt = '0;
          lat_nxt   = '0;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          if (lat_cnt == LAT_LAST) begin
            update_c = 1'b1;
            lat_nxt  = '0;
            if (round == ROUND_LAST) begin
              round_nxt = ROUND_SAT;
              state_nxt = ST_DONE;
            end else begin
              round_nxt = round + ROUND_W'(1);
            end
          end else begin
            lat_nxt = lat_cnt + LAT_W'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      round   <= '0;
      lat_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      round   <= round_nxt;
      lat_cnt <= lat_nxt;
      busy    <= (state_nxt == ST_RUN);
      done    <= (state_nxt == ST_DONE);
    end
  end

  // One select-and-store register per share
  for (genvar i = 0; i < SHARES; i++) begin : g_share
    mux_reg #(.WIDTH(WIDTH)) u_share (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (load_c | update_c),
      .sel  (load_c),
      .d1   (din[share_lsb(i, WIDTH) +: WIDTH]),
      .d0   (rf_in[share_lsb(i, WIDTH) +: WIDTH]),
      .q    (q[share_lsb(i, WIDTH) +: WIDTH])
    );
  end

endmodule

// File: doc/masked_state_reg.md
# masked_state_reg

Parametrised, share-aware state register with built-in round sequencing for masked block-cipher cores (e.g. SKINNY, 2nd-order, S shares). It generalises the single-bit select-between-two-inputs flip-flop to a SHARES×WIDTH bank that loads the initial shares, then iterates over a round-function output for ROUNDS updates. It also handles round-function latency, stall and done signalling. It sits between the share inputs, the combinational/pipelined round function and the ciphertext output.

## Interface
- SHARES, 3, number of Boolean shares
- WIDTH, 128, bits per share
- ROUNDS, 40, number of round-function updates per run (≥1)
- RF_LAT, 1, round-function latency in cycles between updates (≥1)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  load request, sampled in IDLE/DONE only
- din  in  SHARES*WIDTH  initial shares, share i at [i*WIDTH +: WIDTH]
- rf_in  in  SHARES*WIDTH  round-function output shares, same packing
- stall  in  1  freezes the latency counter and blocks updates
- q  out  SHARES*WIDTH  registered state, feeds round function and output
- round  out  $clog2(ROUNDS+1)  index of the round currently being computed
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse, q holds the final state

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- IDLE:
  - start=1 → q←din, round←0, lat_cnt←0, go RUN.
  - Otherwise q is held.
- RUN:
  - stall=1: nothing changes.
  - stall=0 and lat_cnt<RF_LAT-1: lat_cnt increments.
  - stall=0 and lat_cnt=RF_LAT-1: q←rf_in, lat_cnt←0, round←round+1.
  - If that update is the ROUNDS-th (round was ROUNDS-1), go DONE; round saturates at ROUNDS.
- DONE:
  - done=1, busy=0, q holds the final state.
  - start=1 → behaves as IDLE start (q←din, RUN) for back-to-back runs.
  - Otherwise go IDLE.
- start is ignored in RUN.
- q is never loaded from din and rf_in in the same cycle.
- Shares are never combined: per-bit behaviour is a pure select-and-store, keeping glitch/transition leakage per share.
- When not loading, q holds. No combinational path from din/rf_in to q.

## Timing
- Reset values:
  - q=0, round=0, busy=0, done=0, FSM=IDLE, lat_cnt=0.
  - rst_n low mid-run aborts immediately, with no done pulse.
- start at edge t (IDLE):
  - q=din, busy=1, round=0 after t.
- With stall=0 and RF_LAT=L, updates occur at edges t+L, t+2L, … t+ROUNDS·L.
  - DONE follows the last update.
  - done is high for the cycle after edge t+ROUNDS·L; busy is low in that cycle.
- Total start-to-done latency is ROUNDS·L cycles, plus one cycle per stalled cycle.
- round changes together with q. rf_in must be valid for round r when lat_cnt=L-1 and round=r.
- stall asserted in the final update cycle delays done by exactly the stall duration.

## Structure
- Shared package `masked_state_pkg`:
  - FSM enum type.
  - ROUND_W and LAT_W localparam functions.
  - share-slice helper.
- One sub-module, `mux_reg`:
  - parametrised width.
  - enable + 2:1 select register with asynchronous active-low reset.
  - instantiated once per share.
  - select = load, enable = load | update.
- The top holds only the FSM, lat_cnt and the round counter.

## Test plan
- Reset: rst_n low with random din/rf_in → q=0, round=0, busy=0, done=0; held until start.
- Basic run (SHARES=3, WIDTH=8, ROUNDS=4, RF_LAT=1; rf_in = q+1 per share, din=shares 0x10/0x20/0x30):
  - q=0x10/0x20/0x30 one cycle after start.
  - q=0x14/0x24/0x34 and done pulse 4 cycles after load.
  - The unmasked XOR of the shares is checked every cycle.
- Latency + stall (RF_LAT=3, ROUNDS=2, stall high 2 cycles mid-run):
  - Updates at load+3 and load+8.
  - done at load+8 (pulse after that edge).
  - round steps 0→1→2.
- start during RUN with different din → ignored; final q identical to an unperturbed run.
- Back-to-back: start held high through DONE → new din loaded the cycle after done, busy reasserted; no IDLE cycle in between.
- Reset mid-run (rst_n low at round 2 of 4) → outputs zero asynchronously, no done; a subsequent start completes normally.
